// File: rtl/mant_seq_multiplier_if.sv
// Handshake and data bundle for the sequential mantissa multiplier.
// The multiplier takes the slave side. The operand source and the product
// consumer take the master side.
interface mant_seq_multiplier_if #(
   parameter int MW = 24
);
   logic              in_valid;
   logic              in_ready;
   logic [MW-1:0]     ma_i;
   logic [MW-1:0]     mb_i;
   logic              out_valid;
   logic              out_ready;
   logic [2*MW-1:0]   prod_o;
   logic              norm_o;

   modport slave (
      input  in_valid, ma_i, mb_i, out_ready,
      output in_ready, out_valid, prod_o, norm_o
   );

   modport master (
      output in_valid, ma_i, mb_i, out_ready,
      input  in_ready, out_valid, prod_o, norm_o
   );
endinterface

// File: rtl/mant_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for FPU mantissas, hidden bit included.
// It retires one multiplier bit per cycle. The full 2*MW-bit product is
// ready MW cycles after the operands are accepted. The per-step add is MW+1
// bits wide and is built as a two-half carry-select adder.
module mant_seq_multiplier #(
   parameter int MW = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mant_seq_multiplier_if.slave  bus
);
   localparam int CW = $clog2(MW + 1);
   localparam int LW = MW / 2;       // low half of the carry-select adder
   localparam int HW = MW - LW;      // high half of the carry-select adder

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_nxt;
   logic [MW-1:0]     a_q;
   logic [2*MW-1:0]   p_q;
   logic [CW-1:0]     cnt_q;

   logic [MW-1:0]     p_hi;
   logic [MW-1:0]     addend;
   logic [LW:0]       sum_lo;
   logic [HW:0]       sum_hi0;
   logic [HW:0]       sum_hi1;
   logic [MW:0]       sum;
   logic              last_step;

   assign p_hi      = p_q[2*MW-1:MW];
   assign addend    = p_q[0] ? a_q : '0;
   assign last_step = (cnt_q == CW'(MW - 1));

   // Carry-select add: both high-half results are formed in parallel, then the low-half carry picks one.
   always_comb begin
      sum_lo  = {1'b0, p_hi[LW-1:0]}  + {1'b0, addend[LW-1:0]};
      sum_hi0 = {1'b0, p_hi[MW-1:LW]} + {1'b0, addend[MW-1:LW]};
      sum_hi1 = {1'b0, p_hi[MW-1:LW]} + {1'b0, addend[MW-1:LW]} + {{HW{1'b0}}, 1'b1};
      sum     = {(sum_lo[LW] ? sum_hi1 : sum_hi0), sum_lo[LW-1:0]};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state decode: accept in IDLE, MW steps in CALC, hold in DONE until the product is taken.
   always_comb begin
      // NOTE: the default assignment keeps this block purely combinational, so no latch can be inferred.
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_nxt = CALC;
         CALC:    if (last_step)     state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are decoded from the state register only.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE:    bus.in_ready  = 1'b1;
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: load the operands on accept, then shift one bit per step. P is held in DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the product register is reset as well, so prod_o reads 0 after reset and not a stale product.
      if (!rst_n) begin
         a_q   <= '0;
         p_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.ma_i;
                  p_q   <= {{MW{1'b0}}, bus.mb_i};
                  cnt_q <= '0;
               end
            end
            CALC: begin
               p_q   <= {sum, p_q[MW-1:1]};
               cnt_q <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.prod_o = p_q;
   assign bus.norm_o = p_q[2*MW-1];

endmodule
